// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, flag bit positions and default datapath width for the ALU result stage
package alu_pkg;
   localparam int WIDTH_DEF = 16;
   typedef enum logic [2:0] {
      OP_NOT = 3'd0,
      OP_AND = 3'd1,
      OP_OR  = 3'd2,
      OP_XOR = 3'd3,
      OP_ADD = 3'd4,
      OP_SUB = 3'd5,
      OP_RS6 = 3'd6,
      OP_RS7 = 3'd7
   } op_e;
   localparam int FLG_Z = 0;
   localparam int FLG_N = 1;
   localparam int FLG_C = 2;
   localparam int FLG_V = 3;
endpackage

// File: rtl/alu_result_stage_if.sv
// alu_result_stage_if: upstream/downstream handshake bus plus accumulator and counter taps
interface alu_result_stage_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [WIDTH-1:0] in_result;
   logic             in_cout;
   logic             in_acc_we;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic [3:0]       out_flags;
   logic             out_err;
   logic [WIDTH-1:0] acc;
   logic [CNT_W-1:0] op_count;
   modport master (
      output in_valid, in_op, in_a, in_b, in_result, in_cout, in_acc_we, out_ready,
      input  in_ready, out_valid, out_result, out_flags, out_err, acc, op_count
   );
   modport slave (
      input  in_valid, in_op, in_a, in_b, in_result, in_cout, in_acc_we, out_ready,
      output in_ready, out_valid, out_result, out_flags, out_err, acc, op_count
   );
endinterface

// File: rtl/alu_flag_gen.sv
// alu_flag_gen: combinational Z/N/C/V status and reserved-opcode error from a function-unit result
module alu_flag_gen
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [2:0]       op_i,
   input  logic             a_msb_i,
   input  logic             b_msb_i,
   input  logic [WIDTH-1:0] result_i,
   input  logic             cout_i,
   output logic [3:0]       flags_o,
   output logic             err_o
);
   logic r_msb;
   always_comb begin
      r_msb          = result_i[WIDTH-1];
      err_o          = op_i > OP_SUB;
      flags_o        = '0;
      flags_o[FLG_Z] = result_i == '0;
      flags_o[FLG_N] = r_msb;
      flags_o[FLG_C] = (op_i == OP_ADD || op_i == OP_SUB) && cout_i;
      flags_o[FLG_V] = op_i == OP_ADD ? (a_msb_i == b_msb_i) && (r_msb != a_msb_i) :
                       op_i == OP_SUB ? (a_msb_i != b_msb_i) && (r_msb != a_msb_i) : 1'b0;
   end
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered result/flag FIFO, accumulator feedback and accepted-op counter
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input logic               clk,
   input logic               rst_n,
   alu_result_stage_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   logic [WIDTH-1:0] res_q [DEPTH];
   logic [3:0]       flg_q [DEPTH];
   logic [DEPTH-1:0] err_q;
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] opc_q, opc_d;
   logic [3:0]       flags;
   logic             err, push, pop;
   alu_flag_gen #(.WIDTH(WIDTH)) u_flag (
      .op_i     (bus.in_op),
      .a_msb_i  (bus.in_a[WIDTH-1]),
      .b_msb_i  (bus.in_b[WIDTH-1]),
      .result_i (bus.in_result),
      .cout_i   (bus.in_cout),
      .flags_o  (flags),
      .err_o    (err)
   );
   // in_ready depends only on the registered occupancy, never on out_ready
   always_comb begin
      push  = bus.in_valid && cnt_q != FULL;
      pop   = cnt_q != '0 && bus.out_ready;
      wr_d  = push ? wr_q + 1'b1 : wr_q;
      rd_d  = pop ? rd_q + 1'b1 : rd_q;
      cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      acc_d = push && bus.in_acc_we && !err ? bus.in_result : acc_q;
      opc_d = opc_q + CNT_W'(push);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            res_q[i] <= '0;
            flg_q[i] <= '0;
         end
         err_q <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         acc_q <= '0;
         opc_q <= '0;
      end else begin
         if (push) begin
            res_q[wr_q] <= bus.in_result;
            flg_q[wr_q] <= flags;
            err_q[wr_q] <= err;
         end
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         acc_q <= acc_d;
         opc_q <= opc_d;
      end
   end
   assign bus.in_ready   = cnt_q != FULL;
   assign bus.out_valid  = cnt_q != '0;
   assign bus.out_result = res_q[rd_q];
   assign bus.out_flags  = flg_q[rd_q];
   assign bus.out_err    = err_q[rd_q];
   assign bus.acc        = acc_q;
   assign bus.op_count   = opc_q;
endmodule
